// File: rtl/pokey_kbd_pkg.sv
// Shared types and constants for the POKEY keyboard scan/debounce engine.
package pokey_kbd_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        HELD     = 2'd2,
        RELCHECK = 2'd3
    } kbd_state_e;

    // Debug view of the scanner: FSM state plus end-of-pass flag from the counter.
    typedef struct packed {
        kbd_state_e state;
        logic       pass_end;
    } kbd_dbg_t;

    // Default scan codes whose KR2 return carries shift, control and break.
    localparam logic [5:0] SHIFT_CODE_DEF = 6'h3D;
    localparam logic [5:0] CTRL_CODE_DEF  = 6'h3E;
    localparam logic [5:0] BREAK_CODE_DEF = 6'h3F;

    // KBCODE bit positions.
    localparam int KB_CTRL_BIT  = 7;
    localparam int KB_SHIFT_BIT = 6;

    // Assemble KBCODE from modifier shadows and the accepted scan code.
    function automatic logic [7:0] make_kbcode(input logic ctrl, input logic shift,
                                               input logic [5:0] code);
        logic [7:0] v;
        v = {2'b00, code};
        v[KB_CTRL_BIT]  = ctrl;
        v[KB_SHIFT_BIT] = shift;
        return v;
    endfunction

endpackage

// File: rtl/kbd_scan_counter.sv
// 6-bit scan line counter: advances on each scan step, wraps 63->0,
// synchronously cleared while scanning is halted.
module kbd_scan_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       clr,
    output logic [5:0] count,
    output logic       tc
);

    logic [5:0] count_q;
    logic [5:0] count_d;

    // Next count: clear wins over advance; 6-bit add wraps naturally.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 6'd0;
        end else if (en) begin
            count_d = count_q + 6'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= 6'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == 6'd63);

endmodule

// File: rtl/pokey_kbd_scanner.sv
// POKEY keyboard scanner: drives K, samples KR1/KR2, debounces presses and
// releases over whole scan passes, latches KBCODE and pulses key/break IRQs.
// Handshake: no valid/ready; a scan step is one enn & keybClk & scanEn cycle,
// and all sampling on a step uses K before it advances.
module pokey_kbd_scanner
    import pokey_kbd_pkg::*;
#(
    parameter logic [5:0] SHIFT_CODE = SHIFT_CODE_DEF,
    parameter logic [5:0] CTRL_CODE  = CTRL_CODE_DEF,
    parameter logic [5:0] BREAK_CODE = BREAK_CODE_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enn,
    input  logic       keybClk,
    input  logic       scanEn,
    input  logic       debounceEn,
    input  logic       kr1_n,
    input  logic       kr2_n,
    output logic [5:0] k,
    output logic [7:0] kbcode,
    output logic       keyDown,
    output logic       shiftDown,
    output logic       kbdIrq,
    output logic       breakIrq,
    output kbd_dbg_t   dbg
);

    logic       step;
    logic       halt;
    logic       hit;
    logic       at_cmp;
    logic       accept;
    logic       pass_end;

    kbd_state_e state_q, state_d;
    logic [5:0] cmp_q, cmp_d;
    logic [7:0] kbcode_q, kbcode_d;
    logic       key_down_q, key_down_d;
    logic       shift_down_q, shift_down_d;
    logic       shift_shadow_q, shift_shadow_d;
    logic       ctrl_shadow_q, ctrl_shadow_d;
    logic       brk_seen_q, brk_seen_d;
    logic       kbd_irq_q, kbd_irq_d;
    logic       break_irq_q, break_irq_d;

    assign step   = enn & keybClk & scanEn;
    assign halt   = enn & ~scanEn;
    assign hit    = ~kr1_n;
    assign at_cmp = (k == cmp_q);

    kbd_scan_counter u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .en     (step),
        .clr    (halt),
        .count  (k),
        .tc     (pass_end)
    );

    // Next-state: modifier sampling, break edge detect and debounce FSM.
    always_comb begin
        state_d        = state_q;
        cmp_d          = cmp_q;
        kbcode_d       = kbcode_q;
        key_down_d     = key_down_q;
        shift_down_d   = shift_down_q;
        shift_shadow_d = shift_shadow_q;
        ctrl_shadow_d  = ctrl_shadow_q;
        brk_seen_d     = brk_seen_q;
        kbd_irq_d      = 1'b0;
        break_irq_d    = 1'b0;
        accept         = 1'b0;

        if (halt) begin
            state_d    = IDLE;
            key_down_d = 1'b0;
        end else if (step) begin
            if (k == SHIFT_CODE) begin
                shift_shadow_d = ~kr2_n;
                shift_down_d   = ~kr2_n;
            end
            if (k == CTRL_CODE) begin
                ctrl_shadow_d = ~kr2_n;
            end
            if (k == BREAK_CODE) begin
                brk_seen_d  = ~kr2_n;
                break_irq_d = ~kr2_n & ~brk_seen_q;
            end

            case (state_q)
                IDLE: begin
                    if (hit) begin
                        cmp_d = k;
                        if (debounceEn) state_d = CHECK;
                        else            accept  = 1'b1;
                    end
                end
                CHECK: begin
                    if (at_cmp) begin
                        if (hit) accept  = 1'b1;
                        else     state_d = IDLE;
                    end
                end
                HELD: begin
                    if (at_cmp && !hit) begin
                        if (debounceEn) begin
                            state_d = RELCHECK;
                        end else begin
                            key_down_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                end
                RELCHECK: begin
                    if (at_cmp) begin
                        if (hit) begin
                            state_d = HELD;
                        end else begin
                            key_down_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Acceptance uses the modifier shadows from before this step.
            if (accept) begin
                kbcode_d   = make_kbcode(ctrl_shadow_q, shift_shadow_q, k);
                key_down_d = 1'b1;
                kbd_irq_d  = 1'b1;
                state_d    = HELD;
            end
        end
    end

    // State registers; IRQ flops load every cycle so pulses last one clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            cmp_q          <= 6'd0;
            kbcode_q       <= 8'h00;
            key_down_q     <= 1'b0;
            shift_down_q   <= 1'b0;
            shift_shadow_q <= 1'b0;
            ctrl_shadow_q  <= 1'b0;
            brk_seen_q     <= 1'b0;
            kbd_irq_q      <= 1'b0;
            break_irq_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmp_q          <= cmp_d;
            kbcode_q       <= kbcode_d;
            key_down_q     <= key_down_d;
            shift_down_q   <= shift_down_d;
            shift_shadow_q <= shift_shadow_d;
            ctrl_shadow_q  <= ctrl_shadow_d;
            brk_seen_q     <= brk_seen_d;
            kbd_irq_q      <= kbd_irq_d;
            break_irq_q    <= break_irq_d;
        end
    end

    assign kbcode       = kbcode_q;
    assign keyDown      = key_down_q;
    assign shiftDown    = shift_down_q;
    assign kbdIrq       = kbd_irq_q;
    assign breakIrq     = break_irq_q;
    assign dbg.state    = state_q;
    assign dbg.pass_end = pass_end;

endmodule

// File: tb/tb_pokey_kbd_scanner.sv
// Bench for pokey_kbd_scanner: keyboard matrix model drives KR1/KR2 from the
// bench's own scan count; a reference model pushes the expected output word
// per scan step and the word is popped and compared after the edge.
module tb_pokey_kbd_scanner;
    import pokey_kbd_pkg::*;

    localparam int W = 21;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic       enn = 1'b1;
    logic       keybClk = 1'b0;
    logic       scanEn = 1'b1;
    logic       debounceEn = 1'b1;
    logic       kr1_n = 1'b1;
    logic       kr2_n = 1'b1;
    logic [5:0] k;
    logic [7:0] kbcode;
    logic       keyDown, shiftDown, kbdIrq, breakIrq;
    kbd_dbg_t   dbg;

    pokey_kbd_scanner dut (
        .clk        (clk),
        .resetn     (resetn),
        .enn        (enn),
        .keybClk    (keybClk),
        .scanEn     (scanEn),
        .debounceEn (debounceEn),
        .kr1_n      (kr1_n),
        .kr2_n      (kr2_n),
        .k          (k),
        .kbcode     (kbcode),
        .keyDown    (keyDown),
        .shiftDown  (shiftDown),
        .kbdIrq     (kbdIrq),
        .breakIrq   (breakIrq),
        .dbg        (dbg)
    );

    // ---------------- matrix and reference model ----------------
    bit key_held [64];
    bit kr2_held [64];

    logic [5:0] m_k;
    kbd_state_e m_state;
    logic [5:0] m_cmp;
    logic [7:0] m_kbcode;
    logic       m_keydown, m_shiftdown, m_shift_sh, m_ctrl_sh, m_brk_prev;
    logic       m_kirq, m_birq;

    logic [W-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_kirq   = 0;
    int n_birq   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_k = 6'd0; m_state = IDLE; m_cmp = 6'd0; m_kbcode = 8'h00;
        m_keydown = 1'b0; m_shiftdown = 1'b0; m_shift_sh = 1'b0; m_ctrl_sh = 1'b0;
        m_brk_prev = 1'b0; m_kirq = 1'b0; m_birq = 1'b0;
    endtask

    task automatic model_step(input bit hit, input bit kr2_low);
        bit acc;
        acc = 1'b0;
        m_kirq = 1'b0;
        m_birq = 1'b0;
        case (m_state)
            IDLE:     if (hit) begin m_cmp = m_k; if (debounceEn) m_state = CHECK; else acc = 1'b1; end
            CHECK:    if (m_k == m_cmp) begin if (hit) acc = 1'b1; else m_state = IDLE; end
            HELD:     if (m_k == m_cmp && !hit) begin
                          if (debounceEn) m_state = RELCHECK;
                          else begin m_keydown = 1'b0; m_state = IDLE; end
                      end
            RELCHECK: if (m_k == m_cmp) begin
                          if (hit) m_state = HELD;
                          else begin m_keydown = 1'b0; m_state = IDLE; end
                      end
            default:  m_state = IDLE;
        endcase
        if (acc) begin
            m_kbcode  = {m_ctrl_sh, m_shift_sh, m_k};
            m_keydown = 1'b1;
            m_kirq    = 1'b1;
            m_state   = HELD;
        end
        if (m_k == 6'h3D) begin m_shift_sh = kr2_low; m_shiftdown = kr2_low; end
        if (m_k == 6'h3E) m_ctrl_sh = kr2_low;
        if (m_k == 6'h3F) begin m_birq = kr2_low && !m_brk_prev; m_brk_prev = kr2_low; end
        m_k = m_k + 6'd1;
    endtask

    function automatic logic [W-1:0] pack_model();
        return {m_k, m_kbcode, m_keydown, m_shiftdown, m_kirq, m_birq, m_state, (m_k == 6'd63)};
    endfunction

    function automatic logic [W-1:0] pack_dut();
        return {k, kbcode, keyDown, shiftDown, kbdIrq, breakIrq, dbg.state, dbg.pass_end};
    endfunction

    task automatic compare_pop(input string tag);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_empty_q"}, pack_dut(), {W{1'bx}});
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, pack_dut(), exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One scan step followed by a gap cycle (sometimes enn low with strobe high).
    task automatic do_step();
        @(negedge clk);
        enn = 1'b1; keybClk = 1'b1;
        kr1_n = ~key_held[m_k];
        kr2_n = ~kr2_held[m_k];
        model_step(key_held[m_k], kr2_held[m_k]);
        exp_q.push_back(pack_model());
        @(posedge clk); #1;
        if (kbdIrq)   n_kirq++;
        if (breakIrq) n_birq++;
        compare_pop("step");
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin enn = 1'b0; keybClk = 1'b1; end
        else keybClk = 1'b0;
        @(posedge clk); #1;
        check_eq("gap_hold", W'({k, kbdIrq, breakIrq}), W'({m_k, 2'b00}));
        @(negedge clk);
        enn = 1'b1; keybClk = 1'b0;
    endtask

    task automatic run_pass(input int n);
        for (int p = 0; p < n; p++)
            for (int s = 0; s < 64; s++) do_step();
    endtask

    task automatic halt_scan();
        @(negedge clk);
        enn = 1'b1; scanEn = 1'b0; keybClk = 1'($urandom_range(0, 1));
        m_k = 6'd0; m_state = IDLE; m_keydown = 1'b0; m_kirq = 1'b0; m_birq = 1'b0;
        exp_q.push_back(pack_model());
        @(posedge clk); #1;
        compare_pop("halt");
        @(negedge clk);
        scanEn = 1'b1; keybClk = 1'b0;
    endtask

    task automatic clear_matrix();
        for (int i = 0; i < 64; i++) begin key_held[i] = 1'b0; kr2_held[i] = 1'b0; end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k0, b0;
        clear_matrix();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", pack_dut(), W'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_eq("reset_release", pack_dut(), W'(0));

        // Full pass with no keys: k returns to 0, nothing fires.
        run_pass(1);
        check_eq("idle_pass_k", W'(k), W'(6'd0));
        check_eq("idle_pass_irqs", W'(n_kirq + n_birq), W'(0));

        // Debounced press of 0x12.
        debounceEn = 1'b1;
        key_held[6'h12] = 1'b1;
        k0 = n_kirq;
        run_pass(2);
        check_eq("deb_kbcode", W'({kbcode, keyDown}), W'({8'h12, 1'b1}));
        check_eq("deb_irq_cnt", W'(n_kirq - k0), W'(1));
        key_held[6'h12] = 1'b0;
        run_pass(2);
        check_eq("deb_release", W'(keyDown), W'(0));

        // Single-pass glitch is rejected.
        k0 = n_kirq;
        key_held[6'h12] = 1'b1;
        run_pass(1);
        key_held[6'h12] = 1'b0;
        run_pass(1);
        check_eq("glitch_state", W'(dbg.state), W'(IDLE));
        check_eq("glitch_irq", W'(n_kirq - k0), W'(0));

        // Shift + ctrl with key 0x05.
        kr2_held[6'h3D] = 1'b1; kr2_held[6'h3E] = 1'b1; key_held[6'h05] = 1'b1;
        run_pass(2);
        check_eq("mod_kbcode", W'({kbcode, shiftDown}), W'({8'hC5, 1'b1}));
        clear_matrix();
        run_pass(2);
        check_eq("mod_clear", W'({keyDown, shiftDown}), W'(0));

        // No rollover: second key while 0x20 held.
        k0 = n_kirq;
        key_held[6'h20] = 1'b1;
        run_pass(2);
        key_held[6'h21] = 1'b1;
        run_pass(1);
        check_eq("rollover_code", W'(kbcode), W'(8'h20));
        check_eq("rollover_irq", W'(n_kirq - k0), W'(1));
        key_held[6'h20] = 1'b0;
        run_pass(2);
        check_eq("rollover_release", W'(keyDown), W'(0));
        key_held[6'h21] = 1'b0;
        run_pass(1);

        // Break: one pulse while held.
        b0 = n_birq;
        kr2_held[6'h3F] = 1'b1;
        run_pass(2);
        check_eq("break_once", W'(n_birq - b0), W'(1));
        kr2_held[6'h3F] = 1'b0;
        run_pass(1);

        // Single-pass acceptance without debounce.
        debounceEn = 1'b0;
        k0 = n_kirq;
        key_held[6'h07] = 1'b1;
        run_pass(1);
        check_eq("nodeb_kbcode", W'({kbcode, keyDown}), W'({8'h07, 1'b1}));
        check_eq("nodeb_irq", W'(n_kirq - k0), W'(1));
        key_held[6'h07] = 1'b0;
        run_pass(1);

        // Acceptance and break on the same step.
        k0 = n_kirq; b0 = n_birq;
        key_held[6'h3F] = 1'b1; kr2_held[6'h3F] = 1'b1;
        run_pass(1);
        check_eq("simul_pulses", W'({n_kirq - k0, n_birq - b0}), W'({32'd1, 32'd1}));
        clear_matrix();
        run_pass(1);

        // Randomised key/modifier activity.
        for (int r = 0; r < 6; r++) begin
            clear_matrix();
            debounceEn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) key_held[$urandom_range(0, 63)] = 1'b1;
            kr2_held[6'h3D] = 1'($urandom_range(0, 1));
            kr2_held[6'h3E] = 1'($urandom_range(0, 1));
            kr2_held[6'h3F] = 1'($urandom_range(0, 1));
            run_pass(1);
        end

        // Halt while a key is held.
        clear_matrix();
        debounceEn = 1'b1;
        run_pass(2);
        key_held[6'h10] = 1'b1;
        run_pass(2);
        for (int s = 0; s < 5; s++) do_step();
        halt_scan();
        check_eq("halt_outputs", W'({k, keyDown, kbcode}), W'({6'd0, 1'b0, 8'h10}));
        key_held[6'h10] = 1'b0;
        run_pass(1);

        // Asynchronous reset while in CHECK.
        key_held[6'h15] = 1'b1;
        run_pass(1);
        check_eq("pre_reset_check", W'(dbg.state), W'(CHECK));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("async_reset", pack_dut(), W'(0));
        clear_matrix();
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_eq("post_reset_quiet", pack_dut(), W'(0));
        run_pass(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
